// File: rtl/mem_wb_multi.sv
// Multi-lane MEM/WB pipeline register. It qualifies register-file writes per lane
// and keeps a running count of retired (valid) lanes.
module mem_wb_multi #(
  parameter int LANES = 2,
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int SW    = 6,
  parameter int STAGE = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SW-1:0]      stall,
  input  logic               flush,
  input  logic [LANES-1:0]   i_valid,
  input  logic [LANES*DW-1:0] i_d1,
  input  logic [LANES*DW-1:0] i_d2,
  input  logic [LANES*RW-1:0] i_rn,
  input  logic [LANES-1:0]   i_write_regfile,
  input  logic [LANES-1:0]   i_mem_to_regfile,
  output logic [LANES-1:0]   o_valid,
  output logic [LANES*DW-1:0] o_d1,
  output logic [LANES*DW-1:0] o_d2,
  output logic [LANES*RW-1:0] o_rn,
  output logic [LANES-1:0]   o_write_regfile,
  output logic [LANES-1:0]   o_mem_to_regfile,
  output logic [31:0]        o_retire_cnt
);

  logic [LANES-1:0]    r_valid, r_wr, r_m2r;
  logic [LANES*DW-1:0] r_d1, r_d2;
  logic [LANES*RW-1:0] r_rn;
  logic [31:0]         r_retire_cnt;

  logic [LANES-1:0]    w_wr, w_m2r;
  logic [LANES*DW-1:0] w_d1, w_d2;
  logic [LANES*RW-1:0] w_rn;
  logic [31:0]         w_pop;
  logic                w_bubble;
  logic                w_load;

  assign w_bubble = stall[STAGE] & ~stall[STAGE+1];
  assign w_load   = ~stall[STAGE];

  always_comb begin
    w_wr  = '0;
    w_m2r = '0;
    w_d1  = '0;
    w_d2  = '0;
    w_rn  = '0;
    w_pop = '0;
    for (int k = 0; k < LANES; k++) begin
      if (i_valid[k]) begin
        w_d1[k*DW +: DW] = i_d1[k*DW +: DW];
        w_d2[k*DW +: DW] = i_d2[k*DW +: DW];
        w_rn[k*RW +: RW] = i_rn[k*RW +: RW];
        w_wr[k]  = i_write_regfile[k]  & (i_rn[k*RW +: RW] != '0);
        w_m2r[k] = i_mem_to_regfile[k] & (i_rn[k*RW +: RW] != '0);
      end
      w_pop = w_pop + 32'(i_valid[k]);
    end
    // A later lane writing the same register wins; the earlier lane's write is dropped.
    for (int j = 0; j < LANES; j++) begin
      for (int k = j + 1; k < LANES; k++) begin
        if (i_valid[j] && i_valid[k] && i_write_regfile[j] && i_write_regfile[k] &&
            (i_rn[j*RW +: RW] == i_rn[k*RW +: RW]) && (i_rn[j*RW +: RW] != '0)) begin
          w_wr[j]  = 1'b0;
          w_m2r[j] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= '0;
      r_d1         <= '0;
      r_d2         <= '0;
      r_rn         <= '0;
      r_wr         <= '0;
      r_m2r        <= '0;
      r_retire_cnt <= '0;
    end else if (flush || w_bubble) begin
      r_valid <= '0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_rn    <= '0;
      r_wr    <= '0;
      r_m2r   <= '0;
    end else if (w_load) begin
      r_valid      <= i_valid;
      r_d1         <= w_d1;
      r_d2         <= w_d2;
      r_rn         <= w_rn;
      r_wr         <= w_wr;
      r_m2r        <= w_m2r;
      r_retire_cnt <= r_retire_cnt + w_pop;
    end
  end

  assign o_valid          = r_valid;
  assign o_d1             = r_d1;
  assign o_d2             = r_d2;
  assign o_rn             = r_rn;
  assign o_write_regfile  = r_wr;
  assign o_mem_to_regfile = r_m2r;
  assign o_retire_cnt     = r_retire_cnt;

endmodule

// File: tb/tb_mem_wb_multi.sv
// Directed table-driven bench for mem_wb_multi (LANES=2), plus hand sequences
// for hold, reset during hold, flush+reset and counter wrap.
module tb_mem_wb_multi;
  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  stall;
  logic        flush;
  logic [1:0]  i_valid, i_write_regfile, i_mem_to_regfile;
  logic [63:0] i_d1, i_d2;
  logic [9:0]  i_rn;
  logic [1:0]  o_valid, o_write_regfile, o_mem_to_regfile;
  logic [63:0] o_d1, o_d2;
  logic [9:0]  o_rn;
  logic [31:0] o_retire_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_wb_multi #(.LANES(2), .DW(32), .RW(5), .SW(6), .STAGE(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .i_valid(i_valid), .i_d1(i_d1), .i_d2(i_d2), .i_rn(i_rn),
    .i_write_regfile(i_write_regfile), .i_mem_to_regfile(i_mem_to_regfile),
    .o_valid(o_valid), .o_d1(o_d1), .o_d2(o_d2), .o_rn(o_rn),
    .o_write_regfile(o_write_regfile), .o_mem_to_regfile(o_mem_to_regfile),
    .o_retire_cnt(o_retire_cnt)
  );

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [1:0]  v;
    logic [63:0] d1, d2;
    logic [9:0]  rn;
    logic [1:0]  wr, m2r;
    logic [1:0]  e_v;
    logic [63:0] e_d1, e_d2;
    logic [9:0]  e_rn;
    logic [1:0]  e_wr, e_m2r;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NV = 11;
  vec_t vec [NV];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic check_all(input string tag, input logic [1:0] ev, input logic [63:0] ed1,
                           input logic [63:0] ed2, input logic [9:0] ern, input logic [1:0] ewr,
                           input logic [1:0] em2r, input logic [31:0] ecnt);
    check({tag, ".valid"}, 64'(o_valid), 64'(ev));
    check({tag, ".d1"}, o_d1, ed1);
    check({tag, ".d2"}, o_d2, ed2);
    check({tag, ".rn"}, 64'(o_rn), 64'(ern));
    check({tag, ".wr"}, 64'(o_write_regfile), 64'(ewr));
    check({tag, ".m2r"}, 64'(o_mem_to_regfile), 64'(em2r));
    check({tag, ".cnt"}, 64'(o_retire_cnt), 64'(ecnt));
  endtask

  task automatic drive(input logic [5:0] s, input logic f, input logic [1:0] v,
                       input logic [63:0] d1, input logic [63:0] d2, input logic [9:0] rn,
                       input logic [1:0] wr, input logic [1:0] m2r);
    stall = s; flush = f; i_valid = v; i_d1 = d1; i_d2 = d2; i_rn = rn;
    i_write_regfile = wr; i_mem_to_regfile = m2r;
  endtask

  localparam logic [63:0] D1A = {32'h22, 32'h11};
  localparam logic [63:0] D2A = {32'hB2, 32'hA1};
  localparam logic [9:0]  RNA = {5'd4, 5'd3};

  initial begin
    //        stall       fl  v      d1                      d2                      rn             wr     m2r    | e_v  e_d1                 e_d2              e_rn           e_wr   e_m2r  e_cnt
    vec[0]  = '{6'b000000, 0, 2'b11, D1A, D2A, RNA, 2'b11, 2'b01, 2'b11, D1A, D2A, RNA, 2'b11, 2'b01, 32'd2};
    vec[1]  = '{6'b000000, 0, 2'b11, {32'h44, 32'h33}, 64'h0, {5'd7, 5'd7}, 2'b11, 2'b11,
                2'b11, {32'h44, 32'h33}, 64'h0, {5'd7, 5'd7}, 2'b10, 2'b10, 32'd4};
    vec[2]  = '{6'b000000, 0, 2'b11, {32'h66, 32'h55}, {32'h2, 32'h1}, {5'd0, 5'd5}, 2'b11, 2'b11,
                2'b11, {32'h66, 32'h55}, {32'h2, 32'h1}, {5'd0, 5'd5}, 2'b01, 2'b01, 32'd6};
    vec[3]  = '{6'b000000, 0, 2'b01, {32'hFFFF_FFFF, 32'h77}, {32'hFFFF_FFFF, 32'h88}, {5'h1F, 5'd2}, 2'b11, 2'b11,
                2'b01, {32'h0, 32'h77}, {32'h0, 32'h88}, {5'd0, 5'd2}, 2'b01, 2'b01, 32'd7};
    vec[4]  = '{6'b010000, 0, 2'b11, D1A, D2A, RNA, 2'b11, 2'b01, 2'b00, 64'h0, 64'h0, 10'h0, 2'b00, 2'b00, 32'd7};
    vec[5]  = '{6'b000000, 0, 2'b11, D1A, D2A, RNA, 2'b11, 2'b01, 2'b11, D1A, D2A, RNA, 2'b11, 2'b01, 32'd9};
    vec[6]  = '{6'b000000, 1, 2'b11, D1A, D2A, RNA, 2'b11, 2'b01, 2'b00, 64'h0, 64'h0, 10'h0, 2'b00, 2'b00, 32'd9};
    vec[7]  = '{6'b100000, 0, 2'b11, D1A, D2A, RNA, 2'b11, 2'b01, 2'b11, D1A, D2A, RNA, 2'b11, 2'b01, 32'd11};
    vec[8]  = '{6'b000000, 0, 2'b00, D1A, D2A, RNA, 2'b11, 2'b11, 2'b00, 64'h0, 64'h0, 10'h0, 2'b00, 2'b00, 32'd11};
    vec[9]  = '{6'b110000, 1, 2'b11, D1A, D2A, RNA, 2'b11, 2'b01, 2'b00, 64'h0, 64'h0, 10'h0, 2'b00, 2'b00, 32'd11};
    vec[10] = '{6'b000000, 0, 2'b11, {32'h9, 32'h8}, {32'hB, 32'hA}, {5'd7, 5'd7}, 2'b01, 2'b11,
                2'b11, {32'h9, 32'h8}, {32'hB, 32'hA}, {5'd7, 5'd7}, 2'b01, 2'b11, 32'd13};

    reset = 1'b1;
    drive(6'b0, 1'b0, 2'b11, D1A, D2A, RNA, 2'b11, 2'b11);
    repeat (2) @(negedge clk);
    check_all("reset", 2'b00, 64'h0, 64'h0, 10'h0, 2'b00, 2'b00, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vec[i].stall, vec[i].flush, vec[i].v, vec[i].d1, vec[i].d2, vec[i].rn, vec[i].wr, vec[i].m2r);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vec[i].e_v, vec[i].e_d1, vec[i].e_d2, vec[i].e_rn,
                vec[i].e_wr, vec[i].e_m2r, vec[i].e_cnt);
    end

    // Hold three cycles with different inputs: state from vec[10] must persist.
    drive(6'b110000, 1'b0, 2'b11, D1A, D2A, RNA, 2'b11, 2'b11);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_all($sformatf("hold%0d", c), 2'b11, {32'h9, 32'h8}, {32'hB, 32'hA}, {5'd7, 5'd7},
                2'b01, 2'b11, 32'd13);
    end

    // Reset while holding clears everything including the counter.
    reset = 1'b1;
    @(negedge clk);
    check_all("rst_hold", 2'b00, 64'h0, 64'h0, 10'h0, 2'b00, 2'b00, 32'd0);
    reset = 1'b0;
    drive(6'b000000, 1'b0, 2'b11, D1A, D2A, RNA, 2'b11, 2'b01);
    @(negedge clk);
    check_all("post_rst_load", 2'b11, D1A, D2A, RNA, 2'b11, 2'b01, 32'd2);

    // Flush and reset on the same edge: reset wins, counter goes to zero.
    flush = 1'b1; reset = 1'b1;
    @(negedge clk);
    check_all("flush_rst", 2'b00, 64'h0, 64'h0, 10'h0, 2'b00, 2'b00, 32'd0);
    flush = 1'b0; reset = 1'b0;

    // Counter wrap: preload all ones, then retire two lanes.
    drive(6'b110000, 1'b0, 2'b11, D1A, D2A, RNA, 2'b11, 2'b01);
    force dut.r_retire_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_retire_cnt;
    #1;
    check("wrap_preload", 64'(o_retire_cnt), 64'hFFFF_FFFF);
    @(negedge clk);
    stall = 6'b000000;
    @(negedge clk);
    check("wrap_cnt", 64'(o_retire_cnt), 64'd1);
    check("wrap_valid", 64'(o_valid), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_wb_multi.md
MEM_WB_MULTI -- requirements
Module: mem_wb_multi

Interface
REQ-001 Parameter LANES, default 2, number of parallel issue lanes carried (legal 1..4).
REQ-002 Parameter DW, default 32, data field width per lane.
REQ-003 Parameter RW, default 5, register-number width per lane.
REQ-004 Parameter SW, default 6, stall vector width.
REQ-005 Parameter STAGE, default 4, index of this register's bit in the stall vector (STAGE+1 < SW).
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 stall  input  SW  per-stage stall vector, 1 = Stop.
REQ-009 flush  input  1  pipeline flush (exception/branch recovery).
REQ-010 i_valid  input  LANES  per-lane instruction-valid.
REQ-011 i_d1, i_d2  input  LANES*DW each  per-lane result/memory data; lane k in bits [k*DW +: DW].
REQ-012 i_rn  input  LANES*RW  per-lane destination register; lane k in bits [k*RW +: RW].
REQ-013 i_write_regfile, i_mem_to_regfile  input  LANES each  per-lane control bits.
REQ-014 o_valid, o_d1, o_d2, o_rn, o_write_regfile, o_mem_to_regfile  output  same widths as inputs  registered lane fields.
REQ-015 o_retire_cnt  output  32  count of valid lanes captured since reset.

Function
REQ-016 Priority per edge: reset > flush > bubble > load > hold.
REQ-017 Flush: all lane outputs cleared to zero (valid, data, rn, controls); o_retire_cnt unchanged.
REQ-018 Bubble: stall[STAGE]=1 and stall[STAGE+1]=0 -> all lane outputs cleared to zero, o_retire_cnt unchanged.
REQ-019 Hold: stall[STAGE]=1 and stall[STAGE+1]=1 -> all outputs keep previous values.
REQ-020 Load: stall[STAGE]=0 -> every lane captures its inputs, after the qualification rules in REQ-021..REQ-023; latency exactly one cycle.
REQ-021 Invalid lane at load: captured lane fields all zero regardless of other inputs.
REQ-022 Register 0 at load: lane with i_rn=0 captures o_write_regfile=0 and o_mem_to_regfile=0; data still captured.
REQ-023 Same-destination at load: if lanes j<k are both valid, both write, same non-zero rn -> lane j captures o_write_regfile=0 and o_mem_to_regfile=0 (highest-numbered lane wins); applies pairwise over all lanes.
REQ-024 Retire counter: on load, o_retire_cnt += popcount(i_valid); modulo 2^32 wrap; no change on hold, bubble, flush.
REQ-025 Lanes are independent apart from REQ-023; no cross-lane data movement.
REQ-026 Outputs are pure registers; no combinational path from any input to any output.
REQ-027 With LANES=1, behaviour equals a single-lane MEM/WB register plus valid, rn-0 suppression and counter.

Reset
REQ-028 reset=1 at an edge -> all lane outputs zero, o_retire_cnt=0, regardless of stall/flush.
REQ-029 reset asserted mid-hold or mid-stall -> same as REQ-028; first load after release captures normally.

Verification
REQ-030 Load: LANES=2, stall=0, i_valid=2'b11, lane0 rn=3 d1=0x11, lane1 rn=4 d1=0x22, both write -> next cycle outputs match, both write bits 1, o_retire_cnt=2.
REQ-031 Bubble vs hold: stall=6'b010000 -> outputs zero; stall=6'b110000 after a load -> outputs unchanged over 3 cycles, counter unchanged.
REQ-032 Conflict: both lanes valid, write, rn=7 -> o_write_regfile=2'b10, o_mem_to_regfile lane0=0; rn=0 on lane1 -> lane1 write bit 0, d1 captured.
REQ-033 Flush with stall=0 and valid inputs -> outputs zero, counter unchanged; flush plus reset same edge -> counter 0.
REQ-034 Counter wrap: preload to 0xFFFFFFFF via 2^32-1 loads (or forced), load i_valid=2'b11 -> o_retire_cnt=1.
REQ-035 Invalid lane: i_valid=2'b01, lane1 fields all ones -> lane1 outputs all zero, counter +1.
